// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for a small core. It holds the core in reset,
// clears it, lets it run until halt / end-of-program / cycle limit, drains the
// pipeline and then reports completion with a level req/done handshake.
module prog_sequencer #(
    parameter int D         = 12,
    parameter int END_PC    = 160,
    parameter int TIMEOUT   = 4000,
    parameter int CLR_CYC   = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [D-1:0] prog_ctr,
    input  logic         halt,
    output logic         core_rst,
    output logic         core_en,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [15:0]  cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counters reload with N-1 so the state lasts exactly N cycles.
    localparam logic [3:0]   CLR_LOAD   = 4'(CLR_CYC - 1);
    localparam logic [3:0]   DRAIN_LOAD = 4'(DRAIN_CYC - 1);
    localparam logic [D-1:0] END_PC_V   = D'(END_PC);
    localparam logic [15:0]  TO_LAST    = 16'(TIMEOUT - 1);

    state_t     state, next_state;
    logic       req_q;
    logic [3:0] cnt;
    logic       start;
    logic       end_cond;
    logic       limit;

    assign start    = req & ~req_q;
    assign end_cond = halt | (prog_ctr >= END_PC_V);
    assign limit    = (cycle_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; halt/prog_ctr only matter in RUN
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)              next_state = CLEAR;
            CLEAR:   if (cnt == 4'd0)        next_state = RUN;
            RUN:     if (end_cond || limit)  next_state = DRAIN;
            DRAIN:   if (cnt == 4'd0)        next_state = DONE;
            DONE:    if (!req)               next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Outputs are a pure decode of the registered state
    always_comb begin
        core_rst = 1'b0;
        core_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  core_rst = 1'b1;
            CLEAR: begin core_rst = 1'b1; busy = 1'b1; end
            RUN:   begin core_en  = 1'b1; busy = 1'b1; end
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
            default: core_rst = 1'b1;
        endcase
    end

    // Registered copy of req for rising-edge start detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) req_q <= 1'b0;
        else       req_q <= req;
    end

    // CLEAR/DRAIN down counter, reloaded when either state is entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 4'd0;
        else if (state != CLEAR && next_state == CLEAR)
            cnt <= CLR_LOAD;
        else if (state != DRAIN && next_state == DRAIN)
            cnt <= DRAIN_LOAD;
        else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    // Run statistics: cleared on start, updated only in RUN, held otherwise.
    // The exit cycle of RUN is itself counted; an end condition on the limit
    // cycle takes priority over the timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 16'd0;
            timeout   <= 1'b0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= 16'd0;
            timeout   <= 1'b0;
        end else if (state == RUN) begin
            if (cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
            if (limit && !end_cond)    timeout   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: two instances (default limit and an 8-cycle limit)
// share one randomized stimulus; expected run results are queued per run and
// popped by a monitor when each instance raises done.
module tb_prog_sequencer;

    localparam int TO_A = 4000;
    localparam int TO_B = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        halt;
    logic [11:0] prog_ctr;

    logic        core_rst_a, core_en_a, busy_a, done_a, timeout_a;
    logic [15:0] cycle_cnt_a;
    logic        core_rst_b, core_en_b, busy_b, done_b, timeout_b;
    logic [15:0] cycle_cnt_b;

    typedef struct {
        int cnt;
        int to;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a, last_b;
    int   done_n_a = 0;
    int   done_n_b = 0;
    int   tests = 0;
    int   fails = 0;
    bit   pa = 1'b0;
    bit   pb = 1'b0;

    always #5 clk = ~clk;

    prog_sequencer #(.TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr), .halt(halt),
        .core_rst(core_rst_a), .core_en(core_en_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .cycle_cnt(cycle_cnt_a)
    );

    prog_sequencer #(.TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr), .halt(halt),
        .core_rst(core_rst_b), .core_en(core_en_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .cycle_cnt(cycle_cnt_b)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the run ends on the first RUN cycle k with halt or PC past
    // the end, unless the cycle limit is hit first (k == 0 means never).
    function automatic exp_t model(input int k, input int lim);
        exp_t e;
        if (k > 0 && k <= lim) begin e.cnt = k;   e.to = 0; end
        else                   begin e.cnt = lim; e.to = 1; end
        return e;
    endfunction

    // Monitor: pop and compare on every done rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pa = 1'b0;
                pb = 1'b0;
            end else begin
                if (done_a && !pa) begin
                    done_n_a++;
                    if (q_a.size() == 0) check("a unexpected done", 1, 0);
                    else begin
                        e = q_a.pop_front();
                        check("a cycle_cnt", cycle_cnt_a, e.cnt);
                        check("a timeout", timeout_a, e.to);
                        check("a done decode", {core_rst_a, core_en_a, busy_a}, 0);
                    end
                end
                if (done_b && !pb) begin
                    done_n_b++;
                    if (q_b.size() == 0) check("b unexpected done", 1, 0);
                    else begin
                        e = q_b.pop_front();
                        check("b cycle_cnt", cycle_cnt_b, e.cnt);
                        check("b timeout", timeout_b, e.to);
                        check("b done decode", {core_rst_b, core_en_b, busy_b}, 0);
                    end
                end
                pa = done_a;
                pb = done_b;
            end
        end
    end

    // One run; the caller has arranged that the next posedge samples a start.
    // drop: 0 keep req high, 1 drop it in RUN, 2 drop then re-raise it.
    // low_pc: PC driven before the end (-1 = random below END_PC).
    task automatic do_run(input int k, input int use_pc, input int drop,
                          input int hold, input int low_pc);
        exp_t ea, eb;
        int   ta, tb, c, r;
        ea = model(k, TO_A);
        eb = model(k, TO_B);
        q_a.push_back(ea);
        q_b.push_back(eb);
        last_a = ea;
        last_b = eb;
        ta = done_n_a + 1;
        tb = done_n_b + 1;
        c  = 0;
        while ((done_n_a < ta || done_n_b < tb) && c < 5000) begin
            @(posedge clk); #1;
            c++;
            r = c - 2;
            if (c <= 2) begin
                check("a clear", {core_rst_a, core_en_a, busy_a}, 3'b101);
                check("b clear", {core_rst_b, core_en_b, busy_b}, 3'b101);
            end
            if (c == 3) begin
                check("a run", {core_rst_a, core_en_a, busy_a}, 3'b011);
                check("b run", {core_rst_b, core_en_b, busy_b}, 3'b011);
            end
            if (c == ea.cnt + 4) check("a drain", {core_rst_a, core_en_a, busy_a, done_a}, 4'b0010);
            if (c == eb.cnt + 4) check("b drain", {core_rst_b, core_en_b, busy_b, done_b}, 4'b0010);
            if (c == ea.cnt + 5) check("a done timing", done_a, 1);
            if (c == eb.cnt + 5) check("b done timing", done_b, 1);
            if (c <= 2) begin
                // noise while clearing must be ignored
                halt     = 1'($urandom_range(0, 1));
                prog_ctr = 12'($urandom_range(0, 4095));
            end else begin
                halt = (use_pc == 0 && k > 0 && r == k);
                if (use_pc != 0 && k > 0 && r == k)     prog_ctr = 12'd160;
                else if (use_pc != 0 && k > 0 && r > k) prog_ctr = 12'($urandom_range(160, 4095));
                else if (low_pc >= 0)                   prog_ctr = 12'(low_pc);
                else                                    prog_ctr = 12'($urandom_range(0, 159));
            end
            if (drop != 0 && c == 3) req = 1'b0;
            if (drop == 2 && c == 6) req = 1'b1;
        end
        if (c >= 5000) check("run completes", 0, 1);
        halt     = 1'b0;
        prog_ctr = 12'd0;
        if (req) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("a done held", done_a, 1);
                check("b done held", done_b, 1);
            end
            req = 1'b0;
        end
        @(posedge clk); #1;
        check("a idle after done", {done_a, core_rst_a}, 2'b01);
        check("b idle after done", {done_b, core_rst_b}, 2'b01);
        check("a cnt hold", cycle_cnt_a, last_a.cnt);
        check("a to hold", timeout_a, last_a.to);
        check("b cnt hold", cycle_cnt_b, last_b.cnt);
        check("b to hold", timeout_b, last_b.to);
    endtask

    task automatic start_run(input int k, input int use_pc, input int drop,
                             input int hold, input int low_pc);
        req = 1'b0;
        @(posedge clk); #1;
        req = 1'b1;
        do_run(k, use_pc, drop, hold, low_pc);
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        halt     = 1'b0;
        prog_ctr = 12'd0;
        #1;
        check("reset a", {core_rst_a, core_en_a, busy_a, done_a, timeout_a}, 5'b10000);
        check("reset a cnt", cycle_cnt_a, 0);
        check("reset b", {core_rst_b, core_en_b, busy_b, done_b, timeout_b}, 5'b10000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        start_run(10, 1, 0, 0, 0);   // nominal: PC reaches end on RUN cycle 10
        start_run(5, 0, 0, 0, 40);   // halt on RUN cycle 5 with PC 40
        start_run(0, 0, 0, 0, 0);    // no end: both instances time out
        start_run(8, 0, 0, 0, 0);    // halt on the limit cycle of the short instance
        start_run(9, 0, 0, 0, -1);   // short instance times out one cycle before halt
        start_run(7, 1, 0, 5, -1);   // req held in DONE for 5 cycles
        start_run(6, 0, 1, 0, -1);   // req falls mid-run
        start_run(6, 0, 2, 0, -1);   // req falls and rises again mid-run

        // reset during RUN cycle 3 with req held high across it
        req = 1'b0;
        @(posedge clk); #1;
        req = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun reset a", {core_rst_a, core_en_a, busy_a, done_a, timeout_a}, 5'b10000);
        check("midrun reset a cnt", cycle_cnt_a, 0);
        check("midrun reset b", {core_rst_b, core_en_b, busy_b, done_b, timeout_b}, 5'b10000);
        check("midrun reset b cnt", cycle_cnt_b, 0);
        @(negedge clk);
        reset = 1'b0;
        do_run(4, 0, 0, 2, -1);      // req still high: first edge is a start

        for (int i = 0; i < 25; i++)
            start_run(int'($urandom_range(1, 20)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), -1);

        repeat (3) @(posedge clk);
        check("a queue drained", q_a.size(), 0);
        check("b queue drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have the parameter D, default 12, which sets the program counter width.
REQ-002 The block SHALL have the parameter END_PC, default 160, the first PC value treated as end of program.
REQ-003 The block SHALL have the parameter TIMEOUT, default 4000, the maximum number of RUN cycles.
REQ-004 The block SHALL have the parameter CLR_CYC, default 2, the number of CLEAR cycles (legal range 1-15).
REQ-005 The block SHALL have the parameter DRAIN_CYC, default 2, the number of DRAIN cycles (legal range 1-15).
REQ-006 The block SHALL have the port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have the port req, input, 1 bit: level start request from the bench.
REQ-009 The block SHALL have the port prog_ctr, input, D bits: current PC from the fetch unit.
REQ-010 The block SHALL have the port halt, input, 1 bit: halt instruction decoded this cycle.
REQ-011 The block SHALL have the port core_rst, output, 1 bit: holds the PC and core flags in reset.
REQ-012 The block SHALL have the port core_en, output, 1 bit: enables PC advance and register/memory writes.
REQ-013 The block SHALL have the port busy, output, 1 bit: high in CLEAR, RUN and DRAIN.
REQ-014 The block SHALL have the port done, output, 1 bit: run complete.
REQ-015 The block SHALL have the port timeout, output, 1 bit: the last run ended because the cycle limit was reached.
REQ-016 The block SHALL have the port cycle_cnt, output, 16 bits: number of RUN cycles in the current or last run.

Function
REQ-017 The block SHALL implement the states IDLE, CLEAR, RUN, DRAIN and DONE, with all outputs decoded from registered state only.
REQ-018 Output decoding SHALL be:
- IDLE: core_rst=1, core_en=0.
- CLEAR: core_rst=1, core_en=0, busy=1.
- RUN: core_rst=0, core_en=1, busy=1.
- DRAIN: core_rst=0, core_en=0, busy=1.
- DONE: core_rst=0, core_en=0, done=1.
REQ-019 A start SHALL be a rising edge of req, detected against a registered copy of req (req=1 while the registered copy is 0).
REQ-020 IDLE SHALL go to CLEAR on a start; the transition that enters CLEAR SHALL clear cycle_cnt and timeout.
REQ-021 CLEAR SHALL last exactly CLR_CYC cycles and then go to RUN.
REQ-022 In RUN, cycle_cnt SHALL increment once per cycle, saturating at 16'hFFFF.
REQ-023 RUN SHALL go to DRAIN when halt=1 or prog_ctr >= END_PC (unsigned compare).
REQ-024 RUN SHALL also go to DRAIN when cycle_cnt == TIMEOUT-1 and neither end condition holds; in that case timeout SHALL be set to 1.
REQ-025 If halt or end-of-program coincides with the timeout cycle, the end condition SHALL win and timeout SHALL stay 0.
REQ-026 DRAIN SHALL last exactly DRAIN_CYC cycles and then go to DONE.
REQ-027 DONE SHALL hold until req=0, then go to IDLE; done SHALL fall in the cycle after req is sampled low.
REQ-028 req falling during CLEAR, RUN or DRAIN SHALL be ignored; the run SHALL complete to DONE.
REQ-029 A req rising edge in any state other than IDLE SHALL be ignored.
REQ-030 halt and prog_ctr SHALL be ignored outside RUN.
REQ-031 cycle_cnt and timeout SHALL hold their values through DRAIN, DONE and IDLE until the next CLEAR.
REQ-032 A CLEAR or DRAIN count SHALL use a 4-bit down counter reloaded on state entry.

Reset
REQ-033 When reset=1, the block SHALL immediately (asynchronously) set: state=IDLE, core_rst=1, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0, registered req=0.
REQ-034 Reset asserted mid-run SHALL abort the run with no DRAIN.
REQ-035 After reset is released, a req already held high SHALL count as a start on the first clock edge.

Verification
REQ-036 Nominal run: req rises, bench drives prog_ctr to 160 on the 10th RUN cycle -> CLEAR for 2 cycles, RUN with cycle_cnt=10, DRAIN for 2 cycles, done=1, timeout=0.
REQ-037 Halt: halt=1 on RUN cycle 5 with prog_ctr=40 -> DRAIN entered, cycle_cnt=5, done=1, timeout=0.
REQ-038 Timeout: TIMEOUT=8, prog_ctr held at 0 -> timeout=1, cycle_cnt=8, done=1.
REQ-039 Collision: TIMEOUT=8 with halt=1 on RUN cycle 8 -> timeout=0, cycle_cnt=8.
REQ-040 Handshake: req held high in DONE for 5 cycles -> done stays 1; req low -> IDLE next cycle; a second req rising edge -> new run with cycle_cnt restarting at 0.
REQ-041 Reset mid-run: reset pulsed during RUN cycle 3 -> outputs immediately at reset values; no done pulse; a subsequent req starts a clean run.
